// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save adder arbiter.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int res_width(input int w);
    return w + 2;
  endfunction

  function automatic int rr_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/csa_reduce4.sv
// Two-level 3:2 compression of four unsigned operands into sum/carry vectors.
module csa_reduce4
  import csa_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]            a,
  input  logic [W-1:0]            b,
  input  logic [W-1:0]            c,
  input  logic [W-1:0]            d,
  output logic [res_width(W)-1:0] sum,
  output logic [res_width(W)-1:0] carry
);

  localparam int RW = res_width(W);

  logic [RW-1:0] xa, xb, xc, xd, s1, c1;

  always_comb begin
    xa    = RW'(a);
    xb    = RW'(b);
    xc    = RW'(c);
    xd    = RW'(d);
    s1    = xa ^ xb ^ xc;
    c1    = ((xa & xb) | (xa & xc) | (xb & xc)) << 1;
    sum   = s1 ^ c1 ^ xd;
    // total fits in RW bits, so nothing meaningful is shifted out
    carry = ((s1 & c1) | (s1 & xd) | (c1 & xd)) << 1;
  end

endmodule

// File: rtl/csa_arbiter.sv
// Round-robin arbiter sharing one registered 4-operand CSA + final adder.
module csa_arbiter
  import csa_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int W    = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int RW  = res_width(W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  input  logic [NREQ*W-1:0] op_c,
  input  logic [NREQ*W-1:0] op_d,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RW-1:0]     res_sum,
  output logic [IDW-1:0]    res_id
);

  state_t         state, state_nx;
  logic [IDW-1:0] ptr, win;
  logic           any;
  int             idx;
  logic [W-1:0]   a_q, b_q, c_q, d_q;
  logic [RW-1:0]  csa_s, csa_c, sum_q, carry_q;

  // scan from the far end so the first hit in ptr order is written last
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx[IDW-1:0]]) begin
        win = IDW'(idx);
        any = 1'b1;
      end
    end
  end

  csa_reduce4 #(.W(W)) u_reduce (
    .a     (a_q),
    .b     (b_q),
    .c     (c_q),
    .d     (d_q),
    .sum   (csa_s),
    .carry (csa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any) state_nx = CALC;
      CALC:    state_nx = RESP;
      RESP:    if (res_valid && res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= '0;
      ptr       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
    end else begin
      gnt  <= '0;
      busy <= (state_nx != IDLE);
      case (state)
        IDLE: if (any) begin
          a_q    <= op_a[win*W +: W];
          b_q    <= op_b[win*W +: W];
          c_q    <= op_c[win*W +: W];
          d_q    <= op_d[win*W +: W];
          gnt    <= NREQ'(1) << win;
          res_id <= win;
          ptr    <= IDW'(rr_inc(int'(win), NREQ));
        end
        CALC: begin
          sum_q   <= csa_s;
          carry_q <= csa_c;
        end
        RESP: begin
          // first RESP cycle resolves the carry-propagate add
          if (!res_valid) begin
            res_sum   <= sum_q + carry_q;
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
